// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, issues one-outstanding
// word fetches to instruction memory and presents pc/inst to the IF register.
// A one-entry skid buffer absorbs a response that lands while the pipeline
// is stalled; a branch flushes the output, the skid and any fetch in flight.
//
// state | meaning
// IDLE  | just out of reset, no request yet
// REQ   | request presented at fetch_pc, waiting for imem_ready
// WAIT  | one request outstanding, waiting for imem_rvalid
// HOLD  | skid buffer full, no new request until it drains
// DRAIN | redirected while a request is outstanding, response will be dropped
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_flag,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;
    logic        skid_valid;
    logic        resp_take;
    logic        unused_target_bits;

    // Word alignment: the low target bits carry no information.
    assign unused_target_bits = ^branch_target[1:0];

    // A response is kept only when it answers a live request and no redirect
    // lands in the same cycle. fetch_pc still names the outstanding address
    // here because it only advances when the response returns.
    assign resp_take = (state == S_WAIT) && imem_rvalid && !branch_flag;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; branch handling is folded into each state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                // A request accepted in the branch cycle is still outstanding.
                if (imem_ready) begin
                    state_nxt = branch_flag ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = (stall_flag && !branch_flag) ? S_HOLD : S_REQ;
                end else if (branch_flag) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (branch_flag || !stall_flag) begin
                    state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                // Leave as soon as the stale response is gone, even if
                // another redirect arrives in the same cycle.
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Memory request outputs decode directly from registered state.
    always_comb begin
        imem_req  = (state == S_REQ);
        imem_addr = fetch_pc;
    end

    // Program counter, output entry and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            pc         <= 32'h0;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            skid_pc    <= 32'h0;
            skid_inst  <= NOP_INST;
            skid_valid <= 1'b0;
        end else if (branch_flag) begin
            fetch_pc   <= {branch_target[31:2], 2'b00};
            pc         <= 32'h0;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (resp_take) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (!stall_flag) begin
                // The skid can only be full in HOLD, where no response can
                // arrive, so the two sources never compete.
                if (skid_valid) begin
                    pc         <= skid_pc;
                    inst       <= skid_inst;
                    inst_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (resp_take) begin
                    pc         <= fetch_pc;
                    inst       <= imem_rdata;
                    inst_valid <= 1'b1;
                end else begin
                    pc         <= 32'h0;
                    inst       <= NOP_INST;
                    inst_valid <= 1'b0;
                end
            end else if (resp_take) begin
                skid_pc    <= fetch_pc;
                skid_inst  <= imem_rdata;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule
